// File: rtl/ps2_rx_fifo.sv
// Oversampled PS/2 keyboard receiver: sync + glitch filter, 11-bit frame decode, FWFT scancode FIFO.
// Optional: define PS2_BREAK_DECODE_EN to fold 0xE0/0xF0 prefixes into the {ext, brk} bits of the next entry.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          rd_en_i,
    output logic [9:0]                    rd_data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic [15:0]                   keycode_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          filt_clk, filt_clk_d;
    logic [FW-1:0] filt_cnt;
    logic          fall, data_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_i};
            data_sync  <= {data_sync[0], ps2_data_i};
            filt_clk_d <= filt_clk;
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall     = filt_clk_d & ~filt_clk;
    assign data_bit = data_sync[1];

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo;
    logic          frame_good;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            tmo          <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            frame_good   <= 1'b0;
            keycode_o    <= '0;
        end else begin
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            frame_good   <= 1'b0;
            if (fall) begin
                tmo <= '0;
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state        <= IDLE;
                        parity_err_o <= ~(^shift ^ par_bit);
                        frame_err_o  <= ~data_bit;
                        if ((^shift ^ par_bit) && data_bit) begin
                            frame_good <= 1'b1;
                            keycode_o  <= {keycode_o[7:0], shift};
                        end
                    end
                endcase
            end else if (state == IDLE) begin
                tmo <= '0;
            end else if (tmo == TW'(TIMEOUT_CYC - 2)) begin
                frame_err_o <= 1'b1;
                state       <= IDLE;
                tmo         <= '0;
            end else begin
                tmo <= tmo + 1'b1;
            end
        end
    end

    // shift stays stable in IDLE, so it still holds the code when frame_good is seen.
    logic       push_req;
    logic [9:0] push_data;

`ifdef PS2_BREAK_DECODE_EN
    logic ext_flag, brk_flag;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (parity_err_o || frame_err_o) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (frame_good) begin
            if (shift == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (shift == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign push_req  = frame_good && (shift != 8'hE0) && (shift != 8'hF0);
    assign push_data = {ext_flag, brk_flag, shift};
`else
    assign push_req  = frame_good;
    assign push_data = {2'b00, shift};
`endif

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign pop  = rd_en_i && !empty_o;
    assign push = push_req && (!full_o || pop);

    // NOTE: storage is not reset; rd_data_o is masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= push_req && full_o && !pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    assign empty_o   = (count_o == '0);
    assign full_o    = (count_o == (AW + 1)'(FIFO_DEPTH));
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed frames plus random frames against a queue-based model.
// Honours PS2_BREAK_DECODE_EN in the model when the macro is defined for the build.
module tb_ps2_rx_fifo;
    localparam int F    = 4;
    localparam int T    = 300;
    localparam int D    = 8;
    localparam int HALF = 20;

    logic        clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0;
    logic [9:0]  rd_data;
    logic        empty, full, parity_err, frame_err, overflow;
    logic [3:0]  count;
    logic [15:0] keycode;

    ps2_rx_fifo #(.FILTER_LEN(F), .TIMEOUT_CYC(T), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .rd_en_i(rd_en),
        .rd_data_o(rd_data), .empty_o(empty), .full_o(full), .count_o(count),
        .keycode_o(keycode), .parity_err_o(parity_err), .frame_err_o(frame_err),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters observed from the DUT
    int par_n = 0, frm_n = 0, both_n = 0, ovf_n = 0;
    always @(negedge clk) begin
        if (parity_err) par_n++;
        if (frame_err) frm_n++;
        if (parity_err && frame_err) both_n++;
        if (overflow) ovf_n++;
    end

    // Reference model
    logic [9:0]  mq[$];
    logic [15:0] kc_m = '0;
    logic        ext_m = 1'b0, brk_m = 1'b0;
    int          par_m = 0, frm_m = 0, both_m = 0, ovf_m = 0;

    task automatic model_push(input logic [9:0] v);
        if (mq.size() == D) ovf_m++;
        else mq.push_back(v);
    endtask

    task automatic model_good(input logic [7:0] c);
        kc_m = {kc_m[7:0], c};
`ifdef PS2_BREAK_DECODE_EN
        if (c == 8'hE0) ext_m = 1'b1;
        else if (c == 8'hF0) brk_m = 1'b1;
        else begin
            model_push({ext_m, brk_m, c});
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
`else
        model_push({2'b00, c});
`endif
    endtask

    task automatic model_err();
        ext_m = 1'b0;
        brk_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        mq.delete();
        kc_m = '0;
        model_err();
        repeat (3) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk); #2 ps2_data = b;
        repeat (HALF) @(posedge clk); #2 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk); #2 ps2_clk = 1'b1;
    endtask

    // timing: check empty around the push edge; pop_at: assert rd_en on the push edge
    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit stop_b,
                              input bit timing, input bit pop_at);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit(~^c ^ bad_par);
        @(posedge clk); #2 ps2_data = stop_b;
        repeat (HALF) @(posedge clk); #2 ps2_clk = 1'b0;
        for (int n = 1; n <= HALF; n++) begin
            @(posedge clk); #1;
            if (pop_at && n == F + 3) rd_en = 1'b1;
            if (pop_at && n == F + 4) rd_en = 1'b0;
            if (timing && n == F + 3) check("empty_before_push", empty, 1);
            if (timing && n == F + 4) check("empty_after_push", empty, 0);
        end
        #1 ps2_clk = 1'b1;
        @(posedge clk); #2 ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        if (bad_par) par_m++;
        if (!stop_b) frm_m++;
        if (bad_par && !stop_b) both_m++;
        if (!bad_par && stop_b) model_good(c);
        else model_err();
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] exp;
        exp = (mq.size() > 0) ? mq.pop_front() : 10'h000;
        @(negedge clk);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    initial begin
        int first;
        logic [9:0] head;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_keycode", keycode, 0);
        check("rst_pulses", {parity_err, frame_err, overflow}, 0);
        do_reset();

        // Good frame 0x1C with push timing
        send_frame(8'h1C, 0, 1, 1, 0);
        check("k1c_rd_data", rd_data, 10'h01C);
        check("k1c_keycode", keycode, 16'h001C);
        pop_check("k1c_pop");
        check("k1c_empty", empty, 1);

        // Parity failure
        send_frame(8'h1C, 1, 1, 0, 0);
        check("par_pulses", par_n, par_m);
        check("par_empty", empty, 1);
        check("par_keycode", keycode, 16'h001C);

        // Timeout after start + 3 data bits
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(posedge clk); #2 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk); #2 ps2_clk = 1'b0;
        first = 0;
        for (int n = 1; n <= F + T + 20; n++) begin
            @(posedge clk); #1;
            if (n == HALF) ps2_clk = 1'b1;
            if (frame_err && first == 0) first = n;
        end
        frm_m++;
        model_err();
        check("timeout_latency", first, F + 2 + T);
        check("timeout_pulses", frm_n, frm_m);
        send_frame(8'h32, 0, 1, 0, 0);
        check("after_tmo_keycode", keycode, 16'h1C32);
        pop_check("after_tmo_pop");

        // Parity and stop failures together
        send_frame(8'h5B, 1, 0, 0, 0);
        check("both_pulses", both_n, both_m);
        check("both_empty", empty, 1);

        // Short low glitch on the PS/2 clock with data low
        @(posedge clk); #2 ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (2) @(posedge clk); #2 ps2_clk = 1'b1;
        repeat (T + 20) @(posedge clk);
        #2 ps2_data = 1'b1;
        check("glitch_no_err", frm_n, frm_m);
        send_frame(8'h5A, 0, 1, 0, 0);
        check("glitch_keycode", keycode, kc_m);
        pop_check("glitch_pop");

        // Prefix sequence
        do_reset();
        send_frame(8'hE0, 0, 1, 0, 0);
        send_frame(8'hF0, 0, 1, 0, 0);
        send_frame(8'h75, 0, 1, 0, 0);
        check("prefix_keycode", keycode, 16'hF075);
`ifdef PS2_BREAK_DECODE_EN
        check("prefix_count", count, 1);
        check("prefix_head", rd_data, 10'h375);
`else
        check("prefix_count", count, 3);
        check("prefix_head", rd_data, 10'h0E0);
`endif
        while (mq.size() > 0) pop_check("prefix_pop");

        // Fill to overflow
        do_reset();
        check("reset_clears", {empty, count}, {1'b1, 4'd0});
        for (int c = 1; c <= 9; c++) send_frame(8'(c), 0, 1, 0, 0);
        check("full_flag", full, 1);
        check("full_count", count, 8);
        check("overflow_pulses", ovf_n, 1);
        check("overflow_model", ovf_n, ovf_m);
        check("full_keycode", keycode, 16'h0809);

        // Push and pop on the same edge while full
        head = mq.pop_front();
        @(negedge clk);
        check("full_head", rd_data, head);
        send_frame(8'h0A, 0, 1, 0, 1);
        check("pushpop_count", count, 8);
        check("pushpop_no_ovf", ovf_n, 1);
        for (int i = 0; i < D; i++) pop_check("drain");
        check("drain_empty", empty, 1);

        // Mid-frame reset discards the partial frame
        ps2_bit(1'b0); ps2_bit(1'b1);
        do_reset();
        check("midrst_keycode", keycode, 0);
        send_frame(8'h29, 0, 1, 0, 0);
        check("midrst_keycode2", keycode, 16'h0029);
        pop_check("midrst_pop");

        // Randomised frames with random reads
        for (int k = 0; k < 14; k++) begin
            int npop;
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0,
                       $urandom_range(0, 5) != 0, 0, 0);
            check("rnd_keycode", keycode, kc_m);
            check("rnd_count", count, mq.size());
            npop = $urandom_range(0, mq.size());
            for (int i = 0; i < npop; i++) pop_check("rnd_pop");
        end
        while (mq.size() > 0) pop_check("rnd_drain");
        check("rnd_empty", empty, 1);
        check("tot_parity", par_n, par_m);
        check("tot_frame", frm_n, frm_m);
        check("tot_both", both_n, both_m);
        check("tot_overflow", ovf_n, ovf_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
